// File: rtl/output_port_fifo.sv
// ---------------------------------------------------------------------------
// output_port_fifo
//
// Memory-mapped output port for a small core. A write to OUT_ADDR pushes the
// byte-masked write data into a DEPTH-entry FIFO. The FIFO head is offered to
// a downstream consumer through a valid/ready handshake. When the FIFO is full
// and no entry leaves in the same cycle, a write to OUT_ADDR raises stall to
// hold the core until space frees up.
//
// Optional feature (macro OUTPUT_PORT_FIFO_STATUS_EN):
//   A read at OUT_ADDR+4 returns {overflow, zeros, count} on the next cycle.
//   The overflow flag is sticky: it is set on any stall cycle and cleared by
//   reset or by any write to OUT_ADDR+4. Without the macro, dmem_rdata is
//   always 0 and OUT_ADDR+4 is ignored.
//
// Parameters:
//   OUT_ADDR   address of the output data register (compared with dmem_addr)
//   DEPTH      FIFO entries, power of two from 2 to 64
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   dmem_valid  core request valid
//   dmem_addr   core byte address
//   dmem_wstrb  byte write strobes, all zero means a read
//   dmem_wdata  write data
//   dmem_rdata  registered read data (valid the cycle after the request)
//   stall       combinational hold for a write that cannot be accepted
//   out_valid   FIFO head word available
//   out_data    FIFO head word
//   out_ready   consumer accepts the head word
// ---------------------------------------------------------------------------
module output_port_fifo #(
    parameter logic [31:0] OUT_ADDR = 32'h0200_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [31:0]   dmem_rdata_q, dmem_rdata_d;

    logic          hit_wr;
    logic          push;
    logic          pop;
    logic [31:0]   push_word;

`ifdef OUTPUT_PORT_FIFO_STATUS_EN
    localparam logic [31:0] STATUS_ADDR = OUT_ADDR + 32'd4;
    logic          overflow_q, overflow_d;
`endif

    // Request decode and handshake. A pop in the same cycle frees a slot, so
    // a write to a full FIFO is accepted when the consumer is taking the head.
    always_comb begin
        hit_wr = dmem_valid && (dmem_addr == OUT_ADDR) && (dmem_wstrb != 4'b0000);
        pop    = (count_q != '0) && out_ready;
        push   = hit_wr && ((count_q != FULL_COUNT) || pop);
        stall  = hit_wr && (count_q == FULL_COUNT) && !pop;
    end

    // Unstrobed bytes of the pushed word are forced to zero.
    always_comb begin
        push_word = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (dmem_wstrb[b]) begin
                push_word[8*b +: 8] = dmem_wdata[8*b +: 8];
            end
        end
    end

    // Pointer and occupancy update. Pointers are exactly AW bits wide, so the
    // natural wrap gives the modulo-DEPTH advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Read data path. Only the status register ever returns non-zero data.
    always_comb begin
        dmem_rdata_d = 32'h0;
`ifdef OUTPUT_PORT_FIFO_STATUS_EN
        overflow_d = overflow_q;
        if (stall) begin
            overflow_d = 1'b1;
        end
        if (dmem_valid && (dmem_addr == STATUS_ADDR) && (dmem_wstrb != 4'b0000)) begin
            overflow_d = 1'b0;
        end
        if (dmem_valid && (dmem_addr == STATUS_ADDR) && (dmem_wstrb == 4'b0000)) begin
            dmem_rdata_d = {overflow_q, {(31-CW){1'b0}}, count_q};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dmem_rdata_q <= 32'h0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

`ifdef OUTPUT_PORT_FIFO_STATUS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end
`endif

    // Storage is not reset; a push presented during reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Head is read straight from storage: a freshly pushed word only appears
    // once count has been updated on the following cycle.
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_output_port_fifo.sv
// ---------------------------------------------------------------------------
// tb_output_port_fifo
//
// Directed bench for output_port_fifo with DEPTH = 4. Inputs change 1 ns
// after each rising edge; combinational stall is observed 1 ns after the
// inputs change, registered outputs 1 ns after the edge.
// Expected values for the status register depend on whether
// OUTPUT_PORT_FIFO_STATUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_output_port_fifo;

    localparam logic [31:0] OUT_ADDR = 32'h0200_0000;
    localparam int          DEPTH    = 4;

`ifdef OUTPUT_PORT_FIFO_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int checkCount;
    int passCount;
    int failCount;

    output_port_fifo #(
        .OUT_ADDR (OUT_ADDR),
        .DEPTH    (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present one core request.
    task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                                 input logic [3:0] wstrb, input logic [31:0] wdata);
        dmem_valid = valid;
        dmem_addr  = addr;
        dmem_wstrb = wstrb;
        dmem_wdata = wdata;
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One comparison: count it, report a failure with observed/expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        reset      = 1'b1;
        out_ready  = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        checkOutput("reset_rdata", dmem_rdata, 32'h0);

        // Single full-word write with the consumer ready.
        out_ready = 1'b1;
        applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'h0000_0041);
        #1;
        checkOutput("w41_stall", {31'h0, stall}, 32'h0);
        checkOutput("w41_no_bypass", {31'h0, out_valid}, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("w41_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("w41_data", out_data, 32'h0000_0041);
        tick();
        checkOutput("w41_drained", {31'h0, out_valid}, 32'h0);

        // Byte masking.
        out_ready = 1'b0;
        applyStimulus(1'b1, OUT_ADDR, 4'b0001, 32'hAABB_CCDD);
        tick();
        applyStimulus(1'b1, OUT_ADDR, 4'b0110, 32'hAABB_CCDD);
        tick();
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("mask0001_data", out_data, 32'h0000_00DD);
        out_ready = 1'b1;
        tick();
        checkOutput("mask0110_data", out_data, 32'h00BB_CC00);
        tick();
        checkOutput("mask_drained", {31'h0, out_valid}, 32'h0);

        // Fill to DEPTH with the consumer stalled.
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'(v));
            #1;
            checkOutput($sformatf("fill%0d_stall", v), {31'h0, stall}, 32'h0);
            tick();
        end
        checkOutput("full_head", out_data, 32'h1);

        // Other addresses never stall, even when full.
        applyStimulus(1'b1, OUT_ADDR + 32'd8, 4'b1111, 32'h99);
        #1;
        checkOutput("other_addr_stall", {31'h0, stall}, 32'h0);
        tick();
        applyStimulus(1'b1, OUT_ADDR, 4'b0000, 32'h0);
        #1;
        checkOutput("read_out_addr_stall", {31'h0, stall}, 32'h0);
        tick();
        checkOutput("read_out_addr_rdata", dmem_rdata, 32'h0);

        // Fifth write stalls and keeps stalling while nothing drains.
        applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'h5);
        #1;
        checkOutput("w5_stall", {31'h0, stall}, 32'h1);
        tick();
        checkOutput("w5_stall_hold", {31'h0, stall}, 32'h1);
        checkOutput("w5_head_stable", out_data, 32'h1);
        tick();

        // Status after the stall.
        applyStimulus(1'b1, OUT_ADDR + 32'd4, 4'b0000, 32'h0);
        tick();
        checkOutput("status_full", dmem_rdata, STATUS_EN ? 32'h8000_0004 : 32'h0);

        // Full FIFO, consumer ready, write in the same cycle.
        out_ready = 1'b1;
        applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'h5);
        #1;
        checkOutput("full_pop_push_stall", {31'h0, stall}, 32'h0);
        checkOutput("full_pop_push_head", out_data, 32'h1);
        tick();
        checkOutput("after_swap_head", out_data, 32'h2);
        out_ready = 1'b0;
        applyStimulus(1'b1, OUT_ADDR + 32'd4, 4'b0000, 32'h0);
        tick();
        checkOutput("status_count4", dmem_rdata, STATUS_EN ? 32'h8000_0004 : 32'h0);

        // Clear overflow and drain 2..5 in order.
        out_ready = 1'b1;
        applyStimulus(1'b1, OUT_ADDR + 32'd4, 4'b1111, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("drain_3", out_data, 32'h3);
        tick();
        checkOutput("drain_4", out_data, 32'h4);
        tick();
        checkOutput("drain_5", out_data, 32'h5);
        checkOutput("drain_5_valid", {31'h0, out_valid}, 32'h1);
        tick();
        checkOutput("drain_empty", {31'h0, out_valid}, 32'h0);
        applyStimulus(1'b1, OUT_ADDR + 32'd4, 4'b0000, 32'h0);
        tick();
        checkOutput("status_cleared", dmem_rdata, 32'h0);

        // Reset with three words queued; a write during reset is dropped.
        out_ready = 1'b0;
        for (int v = 10; v <= 12; v++) begin
            applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'(v));
            tick();
        end
        checkOutput("queued_head", out_data, 32'hA);
        reset = 1'b1;
        applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'hD);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        applyStimulus(1'b1, OUT_ADDR, 4'b1111, 32'h7);
        tick();
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("post_rst_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("post_rst_data", out_data, 32'h7);
        out_ready = 1'b1;
        tick();
        checkOutput("post_rst_drained", {31'h0, out_valid}, 32'h0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
